// File: rtl/bsk_prd_pkg.sv
// rtl/bsk_prd_pkg.sv - shared constants and helpers for the PRD command-input block
package bsk_prd_pkg;

    localparam logic [4:0] ADR_GRP0 = 5'h00;
    localparam logic [4:0] ADR_IND0 = 5'h08;
    localparam logic [4:0] ADR_FLG0 = 5'h0C;
    localparam logic [4:0] ADR_CTRL = 5'h10;
    localparam logic [4:0] ADR_ID   = 5'h11;

    localparam logic [63:0] COM_DEFAULT = '1;

    localparam int CTRL_TEST_EN = 0;
    localparam int CTRL_IRQ_EN  = 1;

    function automatic int test_cnt_max(input int clock_in, input int test_freq);
        return clock_in / test_freq / 2;
    endfunction

endpackage

// File: rtl/bsk_prd_com_filter.sv
// rtl/bsk_prd_com_filter.sv - one command channel: 2-FF synchroniser plus debounce counter
module bsk_prd_com_filter
    import bsk_prd_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic aclr,
    input  logic i_com,
    output logic o_level,
    output logic o_chg
);

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_sync1 <= COM_DEFAULT[0];
            r_sync2 <= COM_DEFAULT[0];
        end else begin
            r_sync1 <= i_com;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (FILT_LEN == 0) begin : g_bypass
            assign o_level = r_sync2;
            // r_sync2 takes r_sync1 on the next edge, so a difference here is the change
            assign o_chg   = r_sync1 ^ r_sync2;
        end else begin : g_filt
            localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
            localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

            logic [CW-1:0] r_cnt;
            logic          r_level;
            logic          w_diff;
            logic          w_flip;

            assign w_diff = r_sync2 ^ r_level;
            assign w_flip = w_diff && (r_cnt == CNT_LAST);

            always_ff @(posedge clk or posedge aclr) begin
                if (aclr) begin
                    r_cnt   <= '0;
                    r_level <= COM_DEFAULT[0];
                end else begin
                    if (!w_diff || w_flip) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_flip) begin
                        r_level <= ~r_level;
                    end
                end
            end

            assign o_level = r_level;
            assign o_chg   = w_flip;
        end
    endgenerate

endmodule

// File: rtl/bsk_prd_com_in.sv
// rtl/bsk_prd_com_in.sv - PRD receiver command inputs, indication registers, change irq and test tone
module bsk_prd_com_in
    import bsk_prd_pkg::*;
#(
    parameter int          CH_NUM    = 32,
    parameter int          FILT_LEN  = 4,
    parameter int          CLOCK_IN  = 2_000_000,
    parameter int          TEST_FREQ = 250_000,
    parameter logic [3:0]  CS_CODE   = 4'b1011,
    parameter logic [7:0]  UNIT_CODE = 8'hA4,
    parameter logic [6:0]  VERSION   = 7'h26
) (
    input  logic              clk,
    input  logic              aclr,
    inout  wire  [15:0]       bD,
    input  logic              iRd,
    input  logic              iWr,
    input  logic [4:0]        iA,
    input  logic [3:0]        iCS,
    input  logic              iBl,
    input  logic [CH_NUM-1:0] iCom,
    output logic [CH_NUM-1:0] oComInd,
    output logic              oCS,
    output logic              oIrq,
    output logic              oTest
);

    localparam int NW  = CH_NUM / 16;
    localparam int TCM = test_cnt_max(CLOCK_IN, TEST_FREQ);
    localparam int DW  = (TCM > 1) ? $clog2(TCM) : 1;

    logic              w_cs;
    logic [CH_NUM-1:0] w_filt;
    logic [CH_NUM-1:0] w_chg;
    logic [CH_NUM-1:0] w_clr;
    logic [15:0]       w_rd_data;
    logic              w_commit;
    logic [63:0]       w_filt_pad;
    logic [63:0]       w_ind_pad;
    logic [63:0]       w_flg_pad;
    logic [7:0]        w_grp;

    logic              r_wr_s1;
    logic              r_wr_s2;
    logic              r_wr_d;
    logic              r_hold_v;
    logic [4:0]        r_hold_a;
    logic [15:0]       r_hold_d;
    logic [CH_NUM-1:0] r_ind;
    logic [CH_NUM-1:0] r_flg;
    logic              r_test_en;
    logic              r_irq_en;
    logic              r_irq_n;
    logic [DW-1:0]     r_div;
    logic              r_tclk;

    assign w_cs = (iCS == CS_CODE);
    assign oCS  = ~w_cs;

    generate
        for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
            bsk_prd_com_filter #(.FILT_LEN(FILT_LEN)) u_filt (
                .clk     (clk),
                .aclr    (aclr),
                .i_com   (iCom[i]),
                .o_level (w_filt[i]),
                .o_chg   (w_chg[i])
            );
        end
    endgenerate

    // Address and data are re-captured every clk while the strobe is low, so the
    // commit always uses one coherent pair even if the strobe was barely seen.
    assign w_commit = r_hold_v && r_wr_s2 && !r_wr_d;

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_wr_s1  <= 1'b1;
            r_wr_s2  <= 1'b1;
            r_wr_d   <= 1'b1;
            r_hold_v <= 1'b0;
            r_hold_a <= '0;
            r_hold_d <= '0;
        end else begin
            r_wr_s1 <= iWr;
            r_wr_s2 <= r_wr_s1;
            r_wr_d  <= r_wr_s2;
            if (!r_wr_s2 && w_cs) begin
                r_hold_v <= 1'b1;
                r_hold_a <= iA;
                r_hold_d <= bD;
            end else if (w_commit) begin
                r_hold_v <= 1'b0;
            end
        end
    end

    always_comb begin
        w_clr = '0;
        for (int w = 0; w < NW; w++) begin
            if (w_commit && (r_hold_a == 5'(ADR_FLG0 + w))) begin
                w_clr[16*w +: 16] = r_hold_d;
            end
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_ind     <= '0;
            r_flg     <= '0;
            r_test_en <= 1'b0;
            r_irq_en  <= 1'b0;
            r_irq_n   <= 1'b1;
        end else begin
            // a new change outranks a coincident clear
            r_flg   <= w_chg | (r_flg & ~w_clr);
            r_irq_n <= !(r_irq_en && (|r_flg));
            if (w_commit) begin
                for (int w = 0; w < NW; w++) begin
                    if (r_hold_a == 5'(ADR_IND0 + w)) begin
                        r_ind[16*w +: 16] <= r_hold_d;
                    end
                end
                if (r_hold_a == ADR_CTRL) begin
                    r_test_en <= r_hold_d[CTRL_TEST_EN];
                    r_irq_en  <= r_hold_d[CTRL_IRQ_EN];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_div  <= '0;
            r_tclk <= 1'b0;
        end else if (r_div == '0) begin
            r_div  <= DW'(TCM - 1);
            r_tclk <= ~r_tclk;
        end else begin
            r_div  <= r_div - 1'b1;
        end
    end

    always_comb begin
        w_filt_pad                = COM_DEFAULT;
        w_filt_pad[CH_NUM-1:0]    = w_filt;
        w_ind_pad                 = '0;
        w_ind_pad[CH_NUM-1:0]     = r_ind;
        w_flg_pad                 = '0;
        w_flg_pad[CH_NUM-1:0]     = r_flg;
        w_grp                     = w_filt_pad[8*int'(iA[2:0]) +: 8];
        w_rd_data                 = '0;
        if (iA[4:3] == ADR_GRP0[4:3]) begin
            if (int'(iA[2:0]) < 2*NW) begin
                w_rd_data = {~w_grp[7:4], w_grp[7:4], ~w_grp[3:0], w_grp[3:0]};
            end
        end else if (iA[4:2] == ADR_IND0[4:2]) begin
            if (int'(iA[1:0]) < NW) begin
                w_rd_data = w_ind_pad[16*int'(iA[1:0]) +: 16];
            end
        end else if (iA[4:2] == ADR_FLG0[4:2]) begin
            if (int'(iA[1:0]) < NW) begin
                w_rd_data = w_flg_pad[16*int'(iA[1:0]) +: 16];
            end
        end else if (iA == ADR_CTRL) begin
            w_rd_data[CTRL_TEST_EN] = r_test_en;
            w_rd_data[CTRL_IRQ_EN]  = r_irq_en;
        end else if (iA == ADR_ID) begin
            w_rd_data = {UNIT_CODE, VERSION, r_test_en};
        end
    end

    assign bD      = (w_cs && !iRd) ? w_rd_data : 16'hzzzz;
    assign oComInd = ~r_ind;
    assign oIrq    = r_irq_n;
    assign oTest   = r_tclk && r_test_en && iBl;

endmodule

// File: tb/tb_bsk_prd_com_in.sv
// tb/tb_bsk_prd_com_in.sv - scoreboard bench for bsk_prd_com_in
module tb_bsk_prd_com_in;
    import bsk_prd_pkg::*;

    localparam int         CH  = 32;
    localparam logic [3:0] CSC = 4'b1011;

    logic          clk = 1'b0;
    logic          aclr;
    logic          iRd;
    logic          iWr;
    logic [4:0]    iA;
    logic [3:0]    iCS;
    logic          iBl;
    logic [CH-1:0] iCom;
    wire  [15:0]   bD;
    logic [CH-1:0] oComInd;
    logic          oCS;
    logic          oIrq;
    logic          oTest;
    logic [15:0]   tb_bd;
    logic          tb_oe;
    logic          probe;
    int            ncyc;
    int            checks = 0;
    int            errors = 0;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
        logic [31:0] alt;
    } chk_t;

    chk_t sb[$];

    always #5 clk = ~clk;

    assign bD = tb_oe ? tb_bd : 16'hzzzz;

    bsk_prd_com_in dut (
        .clk     (clk),
        .aclr    (aclr),
        .bD      (bD),
        .iRd     (iRd),
        .iWr     (iWr),
        .iA      (iA),
        .iCS     (iCS),
        .iBl     (iBl),
        .iCom    (iCom),
        .oComInd (oComInd),
        .oCS     (oCS),
        .oIrq    (oIrq),
        .oTest   (oTest)
    );

    always @(posedge clk or posedge aclr) begin
        if (aclr) ncyc <= 0;
        else      ncyc <= ncyc + 1;
    end

    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] act;
        if ((!iRd && iCS == CSC) || probe) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: output presented with nothing expected");
            end else begin
                c = sb.pop_front();
                case (c.kind)
                    0:       act = {16'h0, bD};
                    1:       act = oComInd;
                    2:       act = {31'h0, oIrq};
                    3:       act = {31'h0, oTest};
                    default: act = {31'h0, oCS};
                endcase
                checks++;
                if (act !== c.exp && act !== c.alt) begin
                    errors++;
                    $display("FAIL %s actual=%h expected=%h", c.name, act, c.exp);
                end
            end
        end
    end

    function automatic logic tone(input int n);
        return (((n + 3) / 4) % 2) == 1;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input string nm, input logic [4:0] a, input logic [15:0] e, input logic [15:0] e2);
        iA = a;
        sb.push_back('{name: nm, kind: 0, exp: {16'h0, e}, alt: {16'h0, e2}});
        iRd = 1'b0;
        cyc(1);
        iRd = 1'b1;
    endtask

    task automatic rd1(input string nm, input logic [4:0] a, input logic [15:0] e);
        rd(nm, a, e, e);
    endtask

    task automatic prb(input string nm, input int k, input logic [31:0] e, input logic [31:0] e2);
        sb.push_back('{name: nm, kind: k, exp: e, alt: e2});
        probe = 1'b1;
        cyc(1);
        probe = 1'b0;
    endtask

    task automatic wr_start(input logic [4:0] a, input logic [15:0] d);
        iA    = a;
        tb_bd = d;
        tb_oe = 1'b1;
        iWr   = 1'b0;
    endtask

    task automatic wr_end();
        iWr = 1'b1;
        cyc(4);
        tb_oe = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d, input int len);
        wr_start(a, d);
        cyc(len);
        wr_end();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        aclr  = 1'b1;
        iRd   = 1'b1;
        iWr   = 1'b1;
        iA    = '0;
        iCS   = CSC;
        iBl   = 1'b1;
        iCom  = '1;
        tb_oe = 1'b0;
        tb_bd = '0;
        probe = 1'b0;
        cyc(3);
        aclr = 1'b0;
        cyc(2);

        rd1("grp0_reset", ADR_GRP0, 16'h0F0F);
        rd1("id_reset", ADR_ID, 16'hA44C);
        prb("comind_reset", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        prb("irq_reset", 2, 1, 1);
        prb("tone_reset", 3, 0, 0);
        prb("cs_match", 4, 0, 0);
        rd1("grp4_out_of_range", 5'h04, 16'h0000);
        rd1("adr1f_unmapped", 5'h1F, 16'h0000);
        iCS = 4'b0000;
        prb("cs_nomatch", 4, 1, 1);
        iCS = CSC;

        iCom[5] = 1'b0;
        cyc(6);
        rd1("grp0_ch5", ADR_GRP0, 16'h2D0F);
        rd1("flg0_ch5", ADR_FLG0, 16'h0020);
        iCom[6] = 1'b0;
        cyc(5);
        rd1("grp0_ch6_early", ADR_GRP0, 16'h2D0F);
        rd1("grp0_ch6_on_time", ADR_GRP0, 16'h690F);
        rd1("flg0_ch56", ADR_FLG0, 16'h0060);
        iCom[9] = 1'b0;
        cyc(3);
        iCom[9] = 1'b1;
        cyc(8);
        rd1("grp1_glitch", 5'h01, 16'h0F0F);
        rd1("flg0_glitch", ADR_FLG0, 16'h0060);

        wr(ADR_FLG0, 16'h0060, 4);
        rd1("flg0_w1c", ADR_FLG0, 16'h0000);
        wr(ADR_CTRL, 16'h0002, 4);
        rd1("ctrl_irq_en", ADR_CTRL, 16'h0002);
        prb("irq_idle", 2, 1, 1);
        iCom[17] = 1'b0;
        cyc(6);
        prb("irq_at_flag", 2, 1, 1);
        prb("irq_after_flag", 2, 0, 0);
        rd1("flg1_ch17", 5'h0D, 16'h0002);
        wr(5'h0D, 16'h0002, 4);
        prb("irq_cleared", 2, 1, 1);
        rd1("flg1_cleared", 5'h0D, 16'h0000);
        iCom[17] = 1'b1;
        cyc(8);
        rd1("flg1_rise", 5'h0D, 16'h0002);
        prb("irq_rise", 2, 0, 0);
        wr_start(5'h0D, 16'h0002);
        cyc(1);
        iCom[17] = 1'b0;
        cyc(3);
        wr_end();
        rd1("flg1_set_wins", 5'h0D, 16'h0002);
        wr(5'h0D, 16'h0002, 4);
        rd1("flg1_final_clear", 5'h0D, 16'h0000);

        wr(ADR_IND0, 16'h8001, 4);
        prb("comind_ind0", 1, 32'hFFFF_7FFE, 32'hFFFF_7FFE);
        rd1("ind0_readback", ADR_IND0, 16'h8001);
        wr(5'h09, 16'h1234, 1);
        rd("ind1_short_pulse", 5'h09, 16'h1234, 16'h0000);
        rd1("ind0_untouched", ADR_IND0, 16'h8001);
        wr(5'h0A, 16'hFFFF, 4);
        rd1("ind2_out_of_range", 5'h0A, 16'h0000);
        prb("comind_short", 1, 32'hEDCB_7FFE, 32'hFFFF_7FFE);

        wr(ADR_CTRL, 16'h0001, 4);
        rd1("ctrl_test_en", ADR_CTRL, 16'h0001);
        rd1("id_test_en", ADR_ID, 16'hA44D);
        for (int i = 0; i < 16; i++) begin
            prb("tone_run", 3, {31'h0, tone(ncyc)}, {31'h0, tone(ncyc)});
        end
        iBl = 1'b0;
        for (int i = 0; i < 6; i++) begin
            prb("tone_blocked", 3, 0, 0);
        end
        iBl = 1'b1;

        wr(ADR_CTRL, 16'h0003, 4);
        iCom[6] = 1'b1;
        cyc(8);
        prb("irq_pre_reset", 2, 0, 0);
        iCom[3] = 1'b0;
        cyc(3);
        wr_start(ADR_IND0, 16'h5555);
        cyc(2);
        aclr = 1'b1;
        prb("comind_in_reset", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        prb("irq_in_reset", 2, 1, 1);
        prb("tone_in_reset", 3, 0, 0);
        iCom = '1;
        wr_end();
        aclr = 1'b0;
        cyc(10);
        rd1("ind0_after_reset", ADR_IND0, 16'h0000);
        rd1("ctrl_after_reset", ADR_CTRL, 16'h0000);
        rd1("flg0_after_reset", ADR_FLG0, 16'h0000);
        rd1("flg1_after_reset", 5'h0D, 16'h0000);
        rd1("grp0_after_reset", ADR_GRP0, 16'h0F0F);
        prb("comind_after_reset", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        prb("irq_after_reset", 2, 1, 1);

        cyc(2);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_leftover: actual=%0d entries required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
